// File: rtl/d_format_crack_decoder_if.sv
// Bus bundle between format dispatch (master) and the D-form decode slice (slave).
interface d_format_crack_decoder_if #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regSize                 = 5,
    parameter int immediateSize           = 16,
    parameter int funcUnitCodeSize        = 3
);
    logic                               enable_i;
    logic                               stall_i;
    logic [24:0]                        instFormat_i;
    logic [5:0]                         instructionOpcode_i;
    logic [instructionWidth-1:0]        instruction_i;
    logic [addressWidth-1:0]            instructionAddress_i;
    logic                               is64Bit_i;
    logic [PidSize-1:0]                 instructionPid_i;
    logic [TidSize-1:0]                 instructionTid_i;
    logic [instructionCounterWidth-1:0] instructionMajId_i;

    logic                               busy_o;
    logic                               enable_o;
    logic [opcodeSize-1:0]              opcode_o;
    logic [funcUnitCodeSize-1:0]        functionalUnitType_o;
    logic [addressWidth-1:0]            instructionAddress_o;
    logic                               is64Bit_o;
    logic [PidSize-1:0]                 instPid_o;
    logic [TidSize-1:0]                 instTid_o;
    logic [instructionCounterWidth-1:0] instMajId_o;
    logic [instMinIdWidth-1:0]          instMinId_o;
    logic [instMinIdWidth-1:0]          numMicroOps_o;
    logic [1:0]                         op1rw_o;
    logic [1:0]                         op2rw_o;
    logic                               op1isReg_o;
    logic                               op2isReg_o;
    logic                               immIsExtended_o;
    logic                               immIsShifted_o;
    logic [2*regSize+immediateSize-1:0] instructionBody_o;

    modport master (
        output enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
               instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
               instructionMajId_i,
        input  busy_o, enable_o, opcode_o, functionalUnitType_o, instructionAddress_o,
               is64Bit_o, instPid_o, instTid_o, instMajId_o, instMinId_o, numMicroOps_o,
               op1rw_o, op2rw_o, op1isReg_o, op2isReg_o, immIsExtended_o, immIsShifted_o,
               instructionBody_o
    );

    modport slave (
        input  enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
               instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
               instructionMajId_i,
        output busy_o, enable_o, opcode_o, functionalUnitType_o, instructionAddress_o,
               is64Bit_o, instPid_o, instTid_o, instMajId_o, instMinId_o, numMicroOps_o,
               op1rw_o, op2rw_o, op1isReg_o, op2isReg_o, immIsExtended_o, immIsShifted_o,
               instructionBody_o
    );
endinterface

// File: rtl/d_format_crack_decoder.sv
// D-form decode slice: one instruction per cycle, registered outputs, stall freezes everything.
// Build option DFMT_CRACK_LSM_EN cracks lmw/stmw into one micro-op per register.
module d_format_crack_decoder #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regSize                 = 5,
    parameter int immediateSize           = 16,
    parameter int funcUnitCodeSize        = 3,
    parameter int D                       = 32
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    d_format_crack_decoder_if.slave bus
);
    localparam int BodyWidth = 2*regSize + immediateSize;
    localparam logic [funcUnitCodeSize-1:0] FU_FX = 3'd0;
    localparam logic [funcUnitCodeSize-1:0] FU_CR = 3'd3;
    localparam logic [funcUnitCodeSize-1:0] FU_LS = 3'd4;
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_RD   = 2'b10;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RDWR = 2'b11;

`ifdef DFMT_CRACK_LSM_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CRACK = 1'b1} state_t;
    state_t state_q, state_d;
    logic   lsm_s;
`endif

    logic [instructionWidth-1:0] instr_s;
    logic [5:0]                  opc_s;
    logic [regSize-1:0]          rt_s, ra_s;
    logic [immediateSize-1:0]    imm_s;
    logic                        unused_opc_bits_s;
    logic                        busy_s, accept_s, upd_s;

    logic                        valid_s, op1_reg_s, op2_reg_s, ext_s, shf_s;
    logic [funcUnitCodeSize-1:0] fu_s;
    logic [1:0]                  op1_rw_s, op2_rw_s;

    logic                               enable_q, enable_d;
    logic [opcodeSize-1:0]              opcode_q, opcode_d;
    logic [funcUnitCodeSize-1:0]        fu_q, fu_d;
    logic [addressWidth-1:0]            addr_q, addr_d;
    logic                               is64_q, is64_d;
    logic [PidSize-1:0]                 pid_q, pid_d;
    logic [TidSize-1:0]                 tid_q, tid_d;
    logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
    logic [instMinIdWidth-1:0]          min_id_q, min_id_d;
    logic [instMinIdWidth-1:0]          num_ops_q, num_ops_d;
    logic [1:0]                         op1_rw_q, op1_rw_d, op2_rw_q, op2_rw_d;
    logic                               op1_reg_q, op1_reg_d, op2_reg_q, op2_reg_d;
    logic                               ext_q, ext_d, shf_q, shf_d;
    logic [BodyWidth-1:0]               body_q, body_d;

    assign instr_s           = bus.instruction_i;
    assign opc_s             = bus.instructionOpcode_i;
    assign rt_s              = instr_s[25:21];
    assign ra_s              = instr_s[20:16];
    assign imm_s             = instr_s[15:0];
    assign unused_opc_bits_s = ^instr_s[31:26];
    // Update forms (lwzu, stbu, lfdu, ...) both read and write RA.
    assign upd_s             = opc_s[5] & opc_s[0] & (opc_s != 6'd47);

`ifdef DFMT_CRACK_LSM_EN
    assign lsm_s  = (opc_s == 6'd46) || (opc_s == 6'd47);
    assign busy_s = (state_q == ST_CRACK);
`else
    assign busy_s = 1'b0;
`endif

    assign accept_s = bus.enable_i & (bus.instFormat_i == 25'(D)) & ~bus.stall_i & ~busy_s;

    // Primary-opcode decode of the 40 D-form instructions.
    always_comb begin
        valid_s   = 1'b0;
        fu_s      = FU_FX;
        op1_rw_s  = RW_NONE;
        op2_rw_s  = RW_NONE;
        op1_reg_s = 1'b0;
        op2_reg_s = 1'b0;
        ext_s     = 1'b0;
        shf_s     = 1'b0;
        case (opc_s)
            6'd2, 6'd3: begin
                valid_s = 1'b1; op2_reg_s = 1'b1; op2_rw_s = RW_RD; ext_s = 1'b1;
            end
            6'd7, 6'd8, 6'd12, 6'd13, 6'd14, 6'd15: begin
                valid_s   = 1'b1; op1_reg_s = 1'b1; op1_rw_s = RW_WR;
                op2_reg_s = 1'b1; op2_rw_s  = RW_RD; ext_s = 1'b1;
                shf_s     = (opc_s == 6'd15);
            end
            6'd10, 6'd11: begin
                valid_s = 1'b1; fu_s = FU_CR; op2_reg_s = 1'b1; op2_rw_s = RW_RD;
                ext_s   = (opc_s == 6'd11);
            end
            // Logical immediates: RS is the source in the RT slot, RA is the target.
            6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29: begin
                valid_s   = 1'b1; op1_reg_s = 1'b1; op1_rw_s = RW_RD;
                op2_reg_s = 1'b1; op2_rw_s  = RW_WR; shf_s = opc_s[0];
            end
            6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42, 6'd43,
            6'd46, 6'd48, 6'd49, 6'd50, 6'd51: begin
                valid_s   = 1'b1; fu_s = FU_LS; op1_reg_s = 1'b1; op1_rw_s = RW_WR;
                op2_reg_s = 1'b1; op2_rw_s = upd_s ? RW_RDWR : RW_RD; ext_s = 1'b1;
            end
            6'd36, 6'd37, 6'd38, 6'd39, 6'd44, 6'd45,
            6'd47, 6'd52, 6'd53, 6'd54, 6'd55: begin
                valid_s   = 1'b1; fu_s = FU_LS; op1_reg_s = 1'b1; op1_rw_s = RW_RD;
                op2_reg_s = 1'b1; op2_rw_s = upd_s ? RW_RDWR : RW_RD; ext_s = 1'b1;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Next-state: hold on stall, step the crack sequence, or capture a new instruction.
    always_comb begin
        enable_d  = enable_q;
        opcode_d  = opcode_q;
        fu_d      = fu_q;
        addr_d    = addr_q;
        is64_d    = is64_q;
        pid_d     = pid_q;
        tid_d     = tid_q;
        maj_id_d  = maj_id_q;
        min_id_d  = min_id_q;
        num_ops_d = num_ops_q;
        op1_rw_d  = op1_rw_q;
        op2_rw_d  = op2_rw_q;
        op1_reg_d = op1_reg_q;
        op2_reg_d = op2_reg_q;
        ext_d     = ext_q;
        shf_d     = shf_q;
        body_d    = body_q;
`ifdef DFMT_CRACK_LSM_EN
        state_d   = state_q;
`endif
        if (bus.stall_i) begin
            enable_d = enable_q;
        end
`ifdef DFMT_CRACK_LSM_EN
        else if (state_q == ST_CRACK) begin
            // Next register, next word; the displacement wraps at 16 bits.
            enable_d = 1'b1;
            min_id_d = min_id_q + 7'd1;
            body_d   = {body_q[BodyWidth-1 -: regSize] + 5'd1,
                        body_q[immediateSize +: regSize],
                        body_q[immediateSize-1:0] + 16'd4};
            if (min_id_d == (num_ops_q - 7'd1)) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_CRACK;
            end
        end
`endif
        else if (accept_s && valid_s) begin
            enable_d  = 1'b1;
            opcode_d  = {{(opcodeSize-6){1'b0}}, opc_s};
            fu_d      = fu_s;
            addr_d    = bus.instructionAddress_i;
            is64_d    = bus.is64Bit_i;
            pid_d     = bus.instructionPid_i;
            tid_d     = bus.instructionTid_i;
            maj_id_d  = bus.instructionMajId_i;
            min_id_d  = 7'd0;
            num_ops_d = 7'd1;
            op1_rw_d  = op1_rw_s;
            op2_rw_d  = op2_rw_s;
            op1_reg_d = op1_reg_s;
            op2_reg_d = op2_reg_s;
            ext_d     = ext_s;
            shf_d     = shf_s;
            body_d    = {rt_s, ra_s, imm_s};
`ifdef DFMT_CRACK_LSM_EN
            if (lsm_s && (rt_s != 5'd31)) begin
                num_ops_d = 7'd32 - {2'b00, rt_s};
                state_d   = ST_CRACK;
            end else begin
                state_d   = ST_IDLE;
            end
`endif
        end else begin
            enable_d = 1'b0;
        end
    end

    // State and output registers; reset overrides stall.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            enable_q  <= 1'b0;
            opcode_q  <= '0;
            fu_q      <= '0;
            addr_q    <= '0;
            is64_q    <= 1'b0;
            pid_q     <= '0;
            tid_q     <= '0;
            maj_id_q  <= '0;
            min_id_q  <= '0;
            num_ops_q <= '0;
            op1_rw_q  <= 2'b00;
            op2_rw_q  <= 2'b00;
            op1_reg_q <= 1'b0;
            op2_reg_q <= 1'b0;
            ext_q     <= 1'b0;
            shf_q     <= 1'b0;
            body_q    <= '0;
`ifdef DFMT_CRACK_LSM_EN
            state_q   <= ST_IDLE;
`endif
        end else begin
            enable_q  <= enable_d;
            opcode_q  <= opcode_d;
            fu_q      <= fu_d;
            addr_q    <= addr_d;
            is64_q    <= is64_d;
            pid_q     <= pid_d;
            tid_q     <= tid_d;
            maj_id_q  <= maj_id_d;
            min_id_q  <= min_id_d;
            num_ops_q <= num_ops_d;
            op1_rw_q  <= op1_rw_d;
            op2_rw_q  <= op2_rw_d;
            op1_reg_q <= op1_reg_d;
            op2_reg_q <= op2_reg_d;
            ext_q     <= ext_d;
            shf_q     <= shf_d;
            body_q    <= body_d;
`ifdef DFMT_CRACK_LSM_EN
            state_q   <= state_d;
`endif
        end
    end

    assign bus.busy_o               = busy_s;
    assign bus.enable_o             = enable_q;
    assign bus.opcode_o             = opcode_q;
    assign bus.functionalUnitType_o = fu_q;
    assign bus.instructionAddress_o = addr_q;
    assign bus.is64Bit_o            = is64_q;
    assign bus.instPid_o            = pid_q;
    assign bus.instTid_o            = tid_q;
    assign bus.instMajId_o          = maj_id_q;
    assign bus.instMinId_o          = min_id_q;
    assign bus.numMicroOps_o        = num_ops_q;
    assign bus.op1rw_o              = op1_rw_q;
    assign bus.op2rw_o              = op2_rw_q;
    assign bus.op1isReg_o           = op1_reg_q;
    assign bus.op2isReg_o           = op2_reg_q;
    assign bus.immIsExtended_o      = ext_q;
    assign bus.immIsShifted_o       = shf_q;
    assign bus.instructionBody_o    = body_q;
endmodule
